// File: rtl/psum_collector.sv
// psum_collector: accumulates a programmed number of signed row-sum vectors into
// per-row saturating partial sums, then drains them one row per beat on a valid/ready stream.
module psum_collector #(
  parameter int DWD   = 16,
  parameter int PEROW = 4,
  parameter int PSWD  = 24,
  parameter int CNTWD = 8,
  localparam int RW   = (PEROW > 1) ? $clog2(PEROW) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [CNTWD-1:0]          i_len,
  input  logic                      i_sum_valid,
  output logic                      o_sum_ready,
  input  logic [PEROW-1:0][DWD-1:0] i_sum,
  output logic                      o_psum_valid,
  input  logic                      i_psum_ready,
  output logic [PSWD-1:0]           o_psum,
  output logic [RW-1:0]             o_psum_row,
  output logic                      o_psum_last,
  output logic                      o_busy,
  output logic                      o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [RW-1:0]   LAST_ROW = RW'(PEROW - 1);
  localparam logic [PSWD-1:0] SAT_MAX  = {1'b0, {(PSWD-1){1'b1}}};
  localparam logic [PSWD-1:0] SAT_MIN  = {1'b1, {(PSWD-1){1'b0}}};

  state_t           state_reg, state_next;
  logic [PSWD-1:0]  acc_reg [PEROW];
  logic [PSWD-1:0]  sat_sum [PEROW];
  logic [CNTWD-1:0] cnt_reg, cnt_next;
  logic [RW-1:0]    row_reg, row_next;
  logic             done_reg, done_next;
  logic             acc_clear, acc_en;
  logic             last_row;

  assign last_row = (row_reg == LAST_ROW);

  // One widened adder and clamp per row; overflow shows as disagreeing top bits.
  genvar gi;
  generate
    for (gi = 0; gi < PEROW; gi++) begin : g_row
      logic [PSWD:0] wide_sum;
      assign wide_sum = {acc_reg[gi][PSWD-1], acc_reg[gi]}
                      + {{(PSWD+1-DWD){i_sum[gi][DWD-1]}}, i_sum[gi]};
      assign sat_sum[gi] = (wide_sum[PSWD] == wide_sum[PSWD-1]) ? wide_sum[PSWD-1:0]
                         : (wide_sum[PSWD] ? SAT_MIN : SAT_MAX);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = row_reg;
    done_next  = 1'b0;
    acc_clear  = 1'b0;
    acc_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          acc_clear  = 1'b1;
          cnt_next   = i_len;
          row_next   = '0;
          state_next = (i_len == '0) ? DRAIN : ACC;
        end
      end
      ACC: begin
        if (i_sum_valid) begin
          acc_en   = 1'b1;
          cnt_next = cnt_reg - CNTWD'(1);
          if (cnt_reg == CNTWD'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (i_psum_ready) begin
          if (last_row) begin
            row_next   = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            row_next = row_reg + RW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      row_reg   <= '0;
      done_reg  <= 1'b0;
      for (int r = 0; r < PEROW; r++) begin
        acc_reg[r] <= '0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      done_reg  <= done_next;
      for (int r = 0; r < PEROW; r++) begin
        if (acc_clear) begin
          acc_reg[r] <= '0;
        end else if (acc_en) begin
          acc_reg[r] <= sat_sum[r];
        end
      end
    end
  end

  // Drain data is forced to zero outside DRAIN so idle outputs stay quiet.
  assign o_sum_ready  = (state_reg == ACC);
  assign o_psum_valid = (state_reg == DRAIN);
  assign o_psum       = (state_reg == DRAIN) ? acc_reg[row_reg] : '0;
  assign o_psum_row   = row_reg;
  assign o_psum_last  = (state_reg == DRAIN) && last_row;
  assign o_busy       = (state_reg != IDLE);
  assign o_done       = done_reg;

endmodule
